// File: rtl/bsc_pkg.sv
// Shared types and constants for the bounded sample counter.
package bsc_pkg;

    // Sampling modes; LAST_R behaves exactly like LAST.
    typedef enum logic [1:0] {
        LAST   = 2'd0,
        FIRST  = 2'd1,
        ACCUM  = 2'd2,
        LAST_R = 2'd3
    } mode_e;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_e;

    // Saturation value for the hit counter; truncated to the counter width.
    localparam logic [31:0] HITS_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/bsc_step_clamp.sv
// Combinational next-x: advance by step, clamped so x lands exactly on n.
module bsc_step_clamp #(
    parameter int unsigned W      = 16,
    parameter int unsigned STEP_W = 4
) (
    input  logic [W-1:0]      x_i,
    input  logic [W-1:0]      n_i,
    input  logic [STEP_W-1:0] step_i,
    output logic [W-1:0]      x_next_o
);

    logic [W-1:0] step_ext;
    logic [W:0]   gap;
    logic [W:0]   step_wide;

    // Remaining distance and step compared in W+1 bits so nothing wraps.
    always_comb begin
        step_ext  = W'(step_i);
        gap       = {1'b0, n_i} - {1'b0, x_i};
        step_wide = {1'b0, step_ext};
        x_next_o  = (gap <= step_wide) ? n_i : (x_i + step_ext);
    end

endmodule

// File: rtl/bounded_sample_counter.sv
// Bounded loop counter with selectable sampling, hit count and invariant flag.
module bounded_sample_counter
    import bsc_pkg::*;
#(
    parameter int unsigned W         = 16,
    parameter int unsigned RST_BOUND = 500,
    parameter int unsigned STEP_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [W-1:0]      cfg_bound,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [1:0]        cfg_mode,
    input  logic              sel,
    output logic [W-1:0]      x,
    output logic [W-1:0]      m,
    output logic [W-1:0]      n,
    output logic [W-1:0]      hits,
    output logic              busy,
    output logic              done,
    output logic              inv_ok
);

    localparam logic [W-1:0]      RstBound = W'(RST_BOUND);
    localparam logic [W-1:0]      HitsMax  = HITS_MAX[W-1:0];
    localparam logic [STEP_W-1:0] StepOne  = STEP_W'(1);

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [W-1:0]        x_q, x_d;
    logic [W-1:0]        m_q, m_d;
    logic [W-1:0]        n_q, n_d;
    logic [W-1:0]        hits_q, hits_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic                first_q, first_d;

    logic [W-1:0]        x_next;
    logic [W:0]          acc;

    bsc_step_clamp #(
        .W      (W),
        .STEP_W (STEP_W)
    ) u_step_clamp (
        .x_i      (x_q),
        .n_i      (n_q),
        .step_i   (step_q),
        .x_next_o (x_next)
    );

    // State and datapath registers; synchronous reset restores defaults.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            mode_q  <= LAST;
            x_q     <= '0;
            m_q     <= '0;
            n_q     <= RstBound;
            hits_q  <= '0;
            step_q  <= StepOne;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            x_q     <= x_d;
            m_q     <= m_d;
            n_q     <= n_d;
            hits_q  <= hits_d;
            step_q  <= step_d;
            first_q <= first_d;
        end
    end

    // Next-state: stepping and sampling in RUN, config accept in DONE.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        x_d     = x_q;
        m_d     = m_q;
        n_d     = n_q;
        hits_d  = hits_q;
        step_d  = step_q;
        first_d = first_q;
        acc     = {1'b0, m_q} + {1'b0, x_q};

        case (state_q)
            RUN: begin
                if (x_q < n_q) begin
                    x_d = x_next;
                    if (sel) begin
                        hits_d = (hits_q == HitsMax) ? hits_q : (hits_q + W'(1));
                        case (mode_q)
                            FIRST: begin
                                if (!first_q) begin
                                    m_d     = x_q;
                                    first_d = 1'b1;
                                end
                            end
                            ACCUM:   m_d = acc[W] ? '1 : acc[W-1:0];
                            LAST:    m_d = x_q;
                            LAST_R:  m_d = x_q;
                            default: m_d = x_q;
                        endcase
                    end
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (cfg_valid) begin
                    n_d     = cfg_bound;
                    step_d  = (cfg_step == '0) ? StepOne : cfg_step;
                    mode_d  = mode_e'(cfg_mode);
                    x_d     = '0;
                    m_d     = '0;
                    hits_d  = '0;
                    first_d = 1'b0;
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    // Observables derived directly from registered state.
    always_comb begin
        cfg_ready = (state_q == DONE);
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        x         = x_q;
        m         = m_q;
        n         = n_q;
        hits      = hits_q;
        inv_ok    = (mode_q == ACCUM) ? 1'b1
                  : !((x_q >= n_q) && (n_q != '0) && (m_q >= n_q));
    end

endmodule

// File: tb/tb_bounded_sample_counter.sv
// Scoreboard bench: expected end-of-run observations are queued by the
// stimulus and popped by monitors on each rising edge of done.
module tb_bounded_sample_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16-bit instance (defaults)
    logic        rst, cfg_valid, cfg_ready, sel, busy, done, inv_ok;
    logic [15:0] cfg_bound, x, m, n, hits;
    logic [3:0]  cfg_step;
    logic [1:0]  cfg_mode;

    // 8-bit instance
    logic        rst8, cfg_valid8, cfg_ready8, sel8, busy8, done8, inv_ok8;
    logic [7:0]  cfg_bound8, x8, m8, n8, hits8;
    logic [3:0]  cfg_step8;
    logic [1:0]  cfg_mode8;

    bounded_sample_counter dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_bound(cfg_bound), .cfg_step(cfg_step), .cfg_mode(cfg_mode),
        .sel(sel), .x(x), .m(m), .n(n), .hits(hits),
        .busy(busy), .done(done), .inv_ok(inv_ok)
    );

    bounded_sample_counter #(.W(8), .RST_BOUND(200), .STEP_W(4)) dut8 (
        .clk(clk), .rst(rst8), .cfg_valid(cfg_valid8), .cfg_ready(cfg_ready8),
        .cfg_bound(cfg_bound8), .cfg_step(cfg_step8), .cfg_mode(cfg_mode8),
        .sel(sel8), .x(x8), .m(m8), .n(n8), .hits(hits8),
        .busy(busy8), .done(done8), .inv_ok(inv_ok8)
    );

    typedef struct {
        int unsigned x;
        int unsigned m;
        int unsigned n;
        int unsigned hits;
        int unsigned run;
        int unsigned inv_bad;
    } obs_t;

    obs_t exp_q[$];
    obs_t exp8_q[$];

    int checks = 0;
    int errors = 0;

    function automatic void chk(string name, longint unsigned act, longint unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic void cmp_obs(string tag, obs_t got, obs_t e);
        chk({tag, ".x"},       got.x,       e.x);
        chk({tag, ".m"},       got.m,       e.m);
        chk({tag, ".n"},       got.n,       e.n);
        chk({tag, ".hits"},    got.hits,    e.hits);
        chk({tag, ".run_cyc"}, got.run,     e.run);
        chk({tag, ".inv_bad"}, got.inv_bad, e.inv_bad);
    endfunction

    function automatic obs_t mk(int unsigned xv, int unsigned mv, int unsigned nv,
                                int unsigned hv, int unsigned rv);
        obs_t o;
        o.x = xv; o.m = mv; o.n = nv; o.hits = hv; o.run = rv; o.inv_bad = 0;
        return o;
    endfunction

    // Monitor for the 16-bit instance: counts RUN cycles and watches inv_ok.
    initial begin
        logic        done_prev;
        int unsigned run_cnt;
        int unsigned inv_bad;
        obs_t        got, e;
        done_prev = 1'b0; run_cnt = 0; inv_bad = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                run_cnt = 0; inv_bad = 0;
            end else begin
                if (!inv_ok) inv_bad = 1;
                if (done && !done_prev) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mon16: done rose with no expected entry (x=%0d)", x);
                    end else begin
                        e = exp_q.pop_front();
                        got.x = x; got.m = m; got.n = n; got.hits = hits;
                        got.run = run_cnt; got.inv_bad = inv_bad;
                        cmp_obs("mon16", got, e);
                    end
                    run_cnt = 0; inv_bad = 0;
                end else if (busy) begin
                    run_cnt++;
                end
            end
            done_prev = done;
        end
    end

    // Monitor for the 8-bit instance.
    initial begin
        logic        done_prev;
        int unsigned run_cnt;
        int unsigned inv_bad;
        obs_t        got, e;
        done_prev = 1'b0; run_cnt = 0; inv_bad = 0;
        forever begin
            @(negedge clk);
            if (rst8) begin
                run_cnt = 0; inv_bad = 0;
            end else begin
                if (!inv_ok8) inv_bad = 1;
                if (done8 && !done_prev) begin
                    if (exp8_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL mon8: done rose with no expected entry (x=%0d)", x8);
                    end else begin
                        e = exp8_q.pop_front();
                        got.x = x8; got.m = m8; got.n = n8; got.hits = hits8;
                        got.run = run_cnt; got.inv_bad = inv_bad;
                        cmp_obs("mon8", got, e);
                    end
                    run_cnt = 0; inv_bad = 0;
                end else if (busy8) begin
                    run_cnt++;
                end
            end
            done_prev = done8;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input bit wide8, input int unsigned budget);
        int unsigned k = 0;
        while (!(wide8 ? done8 : done) && k < budget) begin
            tick();
            k++;
        end
        if (!(wide8 ? done8 : done)) begin
            checks++; errors++;
            $display("FAIL wait_done%s: done not seen within %0d cycles", wide8 ? "8" : "16", budget);
        end
    endtask

    task automatic cfg16(input logic [15:0] b, input logic [3:0] s, input logic [1:0] md);
        cfg_bound = b; cfg_step = s; cfg_mode = md; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic cfg8(input logic [7:0] b, input logic [3:0] s, input logic [1:0] md);
        cfg_bound8 = b; cfg_step8 = s; cfg_mode8 = md; cfg_valid8 = 1'b1;
        tick();
        cfg_valid8 = 1'b0;
    endtask

    initial begin
        int unsigned k;
        rst = 1'b1; cfg_valid = 1'b0; cfg_bound = '0; cfg_step = '0; cfg_mode = '0; sel = 1'b1;
        rst8 = 1'b1; cfg_valid8 = 1'b0; cfg_bound8 = '0; cfg_step8 = '0; cfg_mode8 = '0; sel8 = 1'b0;

        // 8-bit instance free-runs its default bound with no samples.
        exp8_q.push_back(mk(200, 0, 200, 0, 201));
        // Test 1: defaults, sel held high.
        exp_q.push_back(mk(500, 499, 500, 500, 501));

        repeat (2) tick();
        chk("rst.x",         x,         0);
        chk("rst.m",         m,         0);
        chk("rst.n",         n,         500);
        chk("rst.hits",      hits,      0);
        chk("rst.busy",      busy,      1);
        chk("rst.done",      done,      0);
        chk("rst.cfg_ready", cfg_ready, 0);
        chk("rst.inv_ok",    inv_ok,    1);
        rst = 1'b0; rst8 = 1'b0;
        wait_done(1'b0, 600);

        // Test 2: bound 10, step 3, LAST -> x 0,3,6,9,10.
        exp_q.push_back(mk(10, 9, 10, 4, 5));
        cfg16(16'd10, 4'd3, 2'd0);
        chk("t2.x_after_cfg", x, 0);
        tick();
        chk("t2.x_step1", x, 3);
        wait_done(1'b0, 20);

        // Test 3: bound 20, FIRST, sel pulses at x=5 and x=12.
        exp_q.push_back(mk(20, 5, 20, 2, 21));
        sel = 1'b0;
        cfg16(16'd20, 4'd1, 2'd1);
        k = 0;
        while (!done && k < 100) begin
            sel = (x == 16'd5) || (x == 16'd12);
            tick();
            k++;
        end
        sel = 1'b0;
        chk("t3.done_seen", done, 1);

        // Test 4: bound 0 -> immediately done, nothing sampled; step 0 accepted.
        exp_q.push_back(mk(0, 0, 0, 0, 1));
        sel = 1'b1;
        cfg16(16'd0, 4'd0, 2'd0);
        wait_done(1'b0, 10);
        chk("t4.cfg_ready", cfg_ready, 1);

        // Test 5: cfg_valid during RUN is ignored; reset mid-run restores defaults.
        sel = 1'b0;
        cfg16(16'd50, 4'd1, 2'd0);
        cfg_bound = 16'd99; cfg_valid = 1'b1;
        k = 0;
        while (x != 16'd7 && k < 20) begin
            chk("t5.cfg_ready_run", cfg_ready, 0);
            chk("t5.n_held", n, 50);
            tick();
            k++;
        end
        chk("t5.x_at_7", x, 7);
        exp_q.push_back(mk(500, 0, 500, 0, 501));
        rst = 1'b1;
        tick();
        rst = 1'b0; cfg_valid = 1'b0;
        chk("t5.rst_x",    x,    0);
        chk("t5.rst_n",    n,    500);
        chk("t5.rst_hits", hits, 0);
        chk("t5.rst_busy", busy, 1);
        wait_done(1'b0, 600);

        // Test 6: 8-bit ACCUM saturates m at 255.
        wait_done(1'b1, 300);
        exp8_q.push_back(mk(200, 255, 200, 200, 201));
        sel8 = 1'b1;
        cfg8(8'd200, 4'd1, 2'd2);
        wait_done(1'b1, 300);
        chk("t6.inv_ok", inv_ok8, 1);

        repeat (3) tick();
        chk("scoreboard16_empty", exp_q.size(), 0);
        chk("scoreboard8_empty",  exp8_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
